pic_ctrl_param: RTL
===================

PIC_CTRL_PARAM -- requirements
Module: pic_ctrl_param

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt request lines (legal values 2..16).
REQ-002 SHALL have parameter IDX_W, default 3, level index width, equal to clog2(NUM_IRQ).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port irq_in, input, NUM_IRQ, interrupt request lines, already synchronous to clk.
REQ-006 SHALL have port cfg_wr, input, 1, one-cycle configuration write strobe.
REQ-007 SHALL have port cfg_addr, input, 2: 0 = mode, 1 = mask, 2 = command, 3 = vector base.
REQ-008 SHALL have port cfg_data, input, 8, configuration write data.
REQ-009 SHALL have port int_ack, input, 1, one-cycle pulse per CPU acknowledge cycle.
REQ-010 SHALL have port INT, output, 1, interrupt request to CPU.
REQ-011 SHALL have port vector, output, 8, interrupt vector, valid with vector_valid.
REQ-012 SHALL have port vector_valid, output, 1, one-cycle vector qualifier.
REQ-013 SHALL have port irr, output, NUM_IRQ, interrupt request register.
REQ-014 SHALL have port isr, output, NUM_IRQ, in-service register.

Function
REQ-015 Mode register SHALL hold: bit0 level_mode (1 = level, 0 = rising edge) and bit1 auto_eoi.
REQ-016 Edge mode: irr[i] SHALL set the cycle after irq_in[i] goes 0->1, using a registered previous sample.
REQ-017 Level mode: irr[i] SHALL equal irq_in[i] registered.
REQ-018 irr SHALL capture masked lines; the mask SHALL gate only priority resolution.
REQ-019 Priority: prio_base holds the lowest-priority level; the order SHALL run from level (prio_base+1) mod NUM_IRQ upward, wrapping.
REQ-020 Candidate = highest-priority bit of irr & ~mask; it SHALL qualify only if it has higher priority than every set isr bit (fully nested).
REQ-021 FSM states SHALL be IDLE, ACK1 and ACK2.
REQ-022 IDLE: INT SHALL be registered high the cycle after a qualified candidate exists; the first int_ack SHALL go to ACK1.
REQ-023 On the first int_ack the block SHALL:
- latch the candidate index;
- set its isr bit;
- clear its irr bit (edge mode only);
- drop INT the next cycle.
REQ-024 Spurious case: if no qualified candidate exists at the first int_ack, the latched index SHALL be NUM_IRQ-1, with no isr or irr change.
REQ-025 ACK1: the second int_ack SHALL give vector = (base + index) mod 256 and vector_valid = 1 for one cycle, then go to IDLE.
REQ-026 At the second int_ack with auto_eoi = 1, the block SHALL clear the latched isr bit (except the spurious case).
REQ-027 ACK2 SHALL be a single-cycle state that emits the vector; INT SHALL not reassert before IDLE.
REQ-028 Command writes (cfg_data[7:5]) SHALL behave as:
- 001: non-specific EOI, clears highest-priority isr bit;
- 011: specific EOI, clears isr[cfg_data[3:0]];
- 101: non-specific EOI plus prio_base = cleared level;
- 110: prio_base = cfg_data[3:0];
- others: ignored.
REQ-029 Index fields at or above NUM_IRQ SHALL be ignored; an EOI with isr = 0 SHALL be a no-op.
REQ-030 A command EOI and an auto-EOI in the same cycle SHALL both take effect (OR of clears).
REQ-031 An edge-mode irr set and an ack clear on the same bit in the same cycle: the set SHALL win.
REQ-032 A mode write (addr 0) SHALL reinitialise:
- isr and irr cleared;
- mask = all ones;
- prio_base = NUM_IRQ-1;
- FSM to IDLE, including mid-sequence;
- base retained.

Reset
REQ-033 On reset the block SHALL clear FSM (to IDLE), INT, vector, vector_valid, irr, isr, mode, base and prio_base = NUM_IRQ-1.
REQ-034 On reset mask SHALL be all ones.
REQ-035 Reset SHALL take effect asynchronously; release SHALL be sampled on clk.

Configuration
REQ-036 Macro PIC_AUTO_ROTATE_EN defined: mode bit2 auto_rotate; when 1, each auto-EOI SHALL also set prio_base to the serviced level.
REQ-037 Macro PIC_AUTO_ROTATE_EN undefined: mode bit2 SHALL be ignored and prio_base SHALL change only via commands or reset.

Verification
REQ-038 Reset, mode = 0, mask = 0x00, base = 0x40, pulse irq_in[3] -> INT high; two int_ack -> vector = 0x43, isr = 0x08, irr = 0x00.
REQ-039 isr[3] set, raise irq[5] -> INT stays low; raise irq[1] -> INT high; ack pair -> vector = base + 1, isr = 0x0A.
REQ-040 Non-specific EOI (cfg_data = 0x20) with isr = 0x0A -> isr = 0x08; specific EOI level 3 (0x63) -> isr = 0x00.
REQ-041 Command 0xC2 (prio_base = 2), irq[1] and irq[4] pending -> vector = base + 4 first.
REQ-042 Auto-EOI with PIC_AUTO_ROTATE_EN and bit2 set: service irq[0] -> isr = 0x00, prio_base = 0; pending irq[0] and irq[1] -> irq[1] served next.
REQ-043 Candidate masked between INT and the first int_ack -> vector = base + NUM_IRQ-1, isr unchanged; mode write during ACK1 -> FSM IDLE, no vector_valid.

Source files
------------

// File: rtl/pic_ctrl_param.sv
// pic_ctrl_param: 8259-style priority interrupt controller with rotating priority and fully nested servicing.
// Optional macro PIC_AUTO_ROTATE_EN enables mode bit2 (rotate priority on auto-EOI).
module pic_ctrl_param #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_data,
    input  logic               int_ack,
    output logic               INT,
    output logic [7:0]         vector,
    output logic               vector_valid,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr
);
    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;
    state_t state, state_n;
    logic level_mode, auto_eoi, spur;
`ifdef PIC_AUTO_ROTATE_EN
    logic auto_rot;
`endif
    logic [NUM_IRQ-1:0] mask, prev, req, ack_set, eoi_clr, auto_clr;
    logic [7:0] base;
    logic [IDX_W-1:0] prio_base, idx, cand, isr_top;
    logic cand_found, isr_found, qual;
    logic mode_wr, cmd_wr, sel, ack1, ack2, ns_eoi;
    logic [2:0] cmd;
    int cand_rank, isr_rank, lvl;

    function automatic logic [NUM_IRQ-1:0] bit_of(input int i);
        return NUM_IRQ'(1) << i;
    endfunction

    assign req     = irr & ~mask;
    assign mode_wr = cfg_wr && cfg_addr == 2'd0;
    assign cmd_wr  = cfg_wr && cfg_addr == 2'd2;
    assign cmd     = cfg_data[7:5];
    assign sel     = int'(cfg_data[3:0]) < NUM_IRQ;
    assign ack1    = state == IDLE && int_ack;
    assign ack2    = state == ACK1 && int_ack;
    assign ns_eoi  = cmd_wr && (cmd == 3'b001 || cmd == 3'b101) && isr_found;
    assign ack_set = ack1 && qual ? bit_of(int'(cand)) : '0;
    assign auto_clr = ack2 && auto_eoi && !spur ? bit_of(int'(idx)) : '0;
    assign eoi_clr = (ns_eoi ? bit_of(int'(isr_top)) : '0)
                   | (cmd_wr && cmd == 3'b011 && sel ? bit_of(int'(cfg_data[3:0])) : '0);

    // Scan lowest to highest priority so the last hit is the highest-priority bit.
    always_comb begin
        cand_found = 1'b0;
        cand = '0;
        cand_rank = 0;
        isr_found = 1'b0;
        isr_top = '0;
        isr_rank = 0;
        lvl = 0;
        for (int k = NUM_IRQ; k >= 1; k--) begin
            lvl = (int'(prio_base) + k) % NUM_IRQ;
            if (req[lvl]) begin
                cand_found = 1'b1;
                cand = lvl[IDX_W-1:0];
                cand_rank = k;
            end
            if (isr[lvl]) begin
                isr_found = 1'b1;
                isr_top = lvl[IDX_W-1:0];
                isr_rank = k;
            end
        end
        qual = cand_found && (!isr_found || cand_rank < isr_rank);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = int_ack ? ACK1 : IDLE;
            ACK1:    state_n = int_ack ? ACK2 : ACK1;
            default: state_n = IDLE;
        endcase
        if (mode_wr) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            INT <= 1'b0;
            vector <= '0;
            vector_valid <= 1'b0;
            irr <= '0;
            isr <= '0;
            mask <= '1;
            prev <= '0;
            base <= '0;
            level_mode <= 1'b0;
            auto_eoi <= 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
            auto_rot <= 1'b0;
`endif
            prio_base <= IDX_W'(NUM_IRQ - 1);
            idx <= '0;
            spur <= 1'b0;
        end else begin
            prev <= irq_in;
            INT <= state == IDLE && !int_ack && !mode_wr && qual;
            vector_valid <= ack2 && !mode_wr;
            if (ack2) vector <= base + 8'(idx);
            if (ack1) begin
                idx <= qual ? cand : IDX_W'(NUM_IRQ - 1);
                spur <= !qual;
            end
            if (mode_wr) begin
                level_mode <= cfg_data[0];
                auto_eoi <= cfg_data[1];
`ifdef PIC_AUTO_ROTATE_EN
                auto_rot <= cfg_data[2];
`endif
                irr <= '0;
                isr <= '0;
                mask <= '1;
                prio_base <= IDX_W'(NUM_IRQ - 1);
            end else begin
                // Edge set is OR'd after the ack clear so a simultaneous new edge survives.
                irr <= level_mode ? irq_in : (irr & ~ack_set) | (irq_in & ~prev);
                isr <= (isr | ack_set) & ~(eoi_clr | auto_clr);
                if (cfg_wr && cfg_addr == 2'd1) mask <= NUM_IRQ'({8'h00, cfg_data});
                if (cfg_wr && cfg_addr == 2'd3) base <= cfg_data;
                if (ns_eoi && cmd == 3'b101) prio_base <= isr_top;
                else if (cmd_wr && cmd == 3'b110 && sel) prio_base <= cfg_data[IDX_W-1:0];
`ifdef PIC_AUTO_ROTATE_EN
                else if (ack2 && auto_eoi && auto_rot && !spur) prio_base <= idx;
`endif
            end
        end
    end
endmodule
